// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue front end: opcode encoding,
// instruction field layout and helpers that say which fields an opcode reads.
package fpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_FADD  = 4'd1,
      OP_FSUB  = 4'd2,
      OP_FMUL  = 4'd3,
      OP_LOAD  = 4'd4,
      OP_STORE = 4'd5
   } fpu_op_e;

   localparam int OPC_LSB = 28;
   localparam int RD_LSB  = 24;
   localparam int RS1_LSB = 20;
   localparam int RS2_LSB = 16;
   localparam int IMM_LSB = 0;

   // The single reserved bit above each register field keeps the word at 32 bits.
   typedef struct packed {
      logic [3:0]  opcode;
      logic        rsvd0;
      logic [2:0]  rd;
      logic        rsvd1;
      logic [2:0]  rs1;
      logic        rsvd2;
      logic [2:0]  rs2;
      logic [15:0] imm;
   } fpu_instr_t;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_STORE;
   endfunction

   function automatic logic uses_rd(input logic [3:0] op);
      return (op == OP_FADD) || (op == OP_FSUB) || (op == OP_FMUL) || (op == OP_LOAD);
   endfunction

   function automatic logic uses_rs1(input logic [3:0] op);
      return (op == OP_FADD) || (op == OP_FSUB) || (op == OP_FMUL) || (op == OP_STORE);
   endfunction

   function automatic logic uses_rs2(input logic [3:0] op);
      return (op == OP_FADD) || (op == OP_FSUB) || (op == OP_FMUL);
   endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Small synchronous FIFO. The pointers carry an extra wrap bit so that
// full and empty can be told apart and the fill level is a plain subtraction.
module fpu_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic             doPush, doPop;

   assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign empty_o = (wrPtr_q == rdPtr_q);
   assign count_o = wrPtr_q - rdPtr_q;
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;
   assign data_o  = mem_q[rdPtr_q[AW-1:0]];

   // Each pointer advances by one on its own operation; both may move in one cycle.
   always_comb begin
      wrPtr_d = doPush ? (wrPtr_q + PTR_ONE) : wrPtr_q;
      rdPtr_d = doPop  ? (rdPtr_q + PTR_ONE) : rdPtr_q;
   end

   // Pointer registers; reset empties the queue without touching storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Storage write at the tail slot.
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem_q[wrPtr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/fpu_issue_queue.sv
// FPU issue front end: buffers host instructions, drops illegal ones at the
// head, stalls on register hazards and issues strictly in order.
module fpu_issue_queue
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int NREG  = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     host_valid,
   input  logic [31:0]              host_instr,
   output logic                     host_ready,
   output logic [31:0]              instructions,
   output logic                     issue_valid,
   input  logic                     fpu_ready,
   input  logic                     wb_valid,
   input  logic [2:0]               wb_rd,
   output logic                     err_illegal,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam logic [3:0] NREG_W = 4'(NREG);

   logic [31:0]     headRaw;
   fpu_instr_t      head;
   logic            fifoFull, fifoEmpty;
   logic            pushEn, popEn, issueFire;
   logic            headIllegal, headHazard;
   logic [7:0]      busyAll;
   logic [NREG-1:0] busy_q, busy_d;

   fpu_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (pushEn),
      .data_i  (host_instr),
      .pop_i   (popEn),
      .data_o  (headRaw),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (occupancy)
   );

   assign head         = fpu_instr_t'(headRaw);
   assign host_ready   = !fifoFull;
   assign pushEn       = host_valid && !fifoFull;
   assign issue_valid  = !fifoEmpty && !headIllegal && !headHazard;
   assign err_illegal  = !fifoEmpty && headIllegal;
   assign issueFire    = issue_valid && fpu_ready;
   assign popEn        = issueFire || err_illegal;
   assign instructions = issue_valid ? head : '0;

   // Classify the head from registered state only; same-cycle writebacks are not bypassed.
   always_comb begin
      busyAll            = '0;
      busyAll[NREG-1:0]  = busy_q;
      headIllegal        = !op_legal(head.opcode);
      if (uses_rd(head.opcode)  && ({1'b0, head.rd}  >= NREG_W)) headIllegal = 1'b1;
      if (uses_rs1(head.opcode) && ({1'b0, head.rs1} >= NREG_W)) headIllegal = 1'b1;
      if (uses_rs2(head.opcode) && ({1'b0, head.rs2} >= NREG_W)) headIllegal = 1'b1;
      headHazard = (uses_rd(head.opcode)  && busyAll[head.rd])  ||
                   (uses_rs1(head.opcode) && busyAll[head.rs1]) ||
                   (uses_rs2(head.opcode) && busyAll[head.rs2]);
   end

   // Scoreboard update: writeback clears, an issued writer sets its destination.
   always_comb begin
      busy_d = busy_q;
      for (int r = 0; r < NREG; r++) begin
         if (wb_valid && (wb_rd == 3'(r))) begin
            busy_d[r] = 1'b0;
         end
         if (issueFire && uses_rd(head.opcode) && (head.rd == 3'(r))) begin
            busy_d[r] = 1'b1;
         end
      end
   end

   // Scoreboard register; reset forgets everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed self-checking bench for fpu_issue_queue.
module tb_fpu_issue_queue;
   import fpu_pkg::*;

   localparam int DEPTH = 4;
   localparam int NREG  = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        host_valid = 1'b0;
   logic [31:0] host_instr = '0;
   logic        host_ready;
   logic [31:0] instructions;
   logic        issue_valid;
   logic        fpu_ready = 1'b0;
   logic        wb_valid = 1'b0;
   logic [2:0]  wb_rd = '0;
   logic        err_illegal;
   logic [2:0]  occupancy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fpu_issue_queue #(.DEPTH(DEPTH), .NREG(NREG)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .host_valid   (host_valid),
      .host_instr   (host_instr),
      .host_ready   (host_ready),
      .instructions (instructions),
      .issue_valid  (issue_valid),
      .fpu_ready    (fpu_ready),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .err_illegal  (err_illegal),
      .occupancy    (occupancy)
   );

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [15:0] imm);
      logic [31:0] w;
      w = '0;
      w[OPC_LSB +: 4]  = op;
      w[RD_LSB  +: 3]  = rd;
      w[RS1_LSB +: 3]  = rs1;
      w[RS2_LSB +: 3]  = rs2;
      w[IMM_LSB +: 16] = imm;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      host_valid = 1'b0;
      host_instr = '0;
      fpu_ready = 1'b0;
      wb_valid = 1'b0;
      wb_rd = '0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      rst_n = 1'b0;
      #2;
      total++; if (host_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_host_ready: got %b want 1", host_ready); end
      total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_issue_valid: got %b want 0", issue_valid); end
      total++; if (instructions !== 32'h0) begin bad++; $display("[TB] FAIL rst_instr: got %h want 00000000", instructions); end
      total++; if (err_illegal !== 1'b0) begin bad++; $display("[TB] FAIL rst_err: got %b want 0", err_illegal); end
      total++; if (occupancy !== 3'd0) begin bad++; $display("[TB] FAIL rst_occ: got %0d want 0", occupancy); end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset_midstream();
      logic [31:0] a;
      do_reset();
      a = mk(4'd1, 3'd1, 3'd2, 3'd3, 16'h0011);
      fpu_ready = 1'b1; host_valid = 1'b1; host_instr = a;
      tick();
      host_valid = 1'b0;
      tick();
      fpu_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         host_valid = 1'b1;
         host_instr = mk(4'd4, 3'(i + 2), 3'd0, 3'd0, 16'(i));
         tick();
      end
      host_valid = 1'b0;
      total++; if (occupancy !== 3'd3) begin bad++; $display("[TB] FAIL mid_occ_before: got %0d want 3", occupancy); end
      rst_n = 1'b0;
      #1;
      total++; if (occupancy !== 3'd0) begin bad++; $display("[TB] FAIL mid_occ_after: got %0d want 0", occupancy); end
      total++; if (host_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_host_ready: got %b want 1", host_ready); end
      total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_issue_valid: got %b want 0", issue_valid); end
      tick();
      rst_n = 1'b1;
      fpu_ready = 1'b1; host_valid = 1'b1; host_instr = a;
      tick();
      host_valid = 1'b0;
      total++; if (issue_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_reissue_valid: got %b want 1", issue_valid); end
      total++; if (instructions !== a) begin bad++; $display("[TB] FAIL mid_reissue_instr: got %h want %h", instructions, a); end
      tick();
      total++; if (occupancy !== 3'd0) begin bad++; $display("[TB] FAIL mid_drain_occ: got %0d want 0", occupancy); end
   endtask

   task automatic test_full();
      logic [31:0] exp [4];
      do_reset();
      for (int i = 0; i < 4; i++) exp[i] = mk(4'd1, 3'(i + 1), 3'd0, 3'd0, 16'(16'hA0 + i));
      for (int i = 0; i < 4; i++) begin
         host_valid = 1'b1; host_instr = exp[i];
         tick();
      end
      total++; if (occupancy !== 3'd4) begin bad++; $display("[TB] FAIL full_occ: got %0d want 4", occupancy); end
      total++; if (host_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_host_ready: got %b want 0", host_ready); end
      host_instr = mk(4'd1, 3'd0, 3'd0, 3'd0, 16'hDEAD);
      tick();
      host_valid = 1'b0;
      total++; if (occupancy !== 3'd4) begin bad++; $display("[TB] FAIL full_fifth_ignored: got %0d want 4", occupancy); end
      total++; if (instructions !== exp[0]) begin bad++; $display("[TB] FAIL full_hold_instr: got %h want %h", instructions, exp[0]); end
      fpu_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++; if (issue_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_drain_valid%0d: got %b want 1", i, issue_valid); end
         total++; if (instructions !== exp[i]) begin bad++; $display("[TB] FAIL full_drain_instr%0d: got %h want %h", i, instructions, exp[i]); end
         tick();
      end
      total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_empty_valid: got %b want 0", issue_valid); end
      total++; if (occupancy !== 3'd0) begin bad++; $display("[TB] FAIL full_empty_occ: got %0d want 0", occupancy); end
   endtask

   task automatic test_hazard_wb();
      logic [31:0] a, b;
      do_reset();
      a = mk(4'd1, 3'd1, 3'd2, 3'd3, 16'h0001);
      b = mk(4'd3, 3'd4, 3'd1, 3'd0, 16'h0002);
      fpu_ready = 1'b1; host_valid = 1'b1; host_instr = a;
      tick();
      total++; if (instructions !== a) begin bad++; $display("[TB] FAIL haz_first_instr: got %h want %h", instructions, a); end
      host_instr = b;
      tick();
      host_valid = 1'b0;
      total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL haz_stall: got %b want 0", issue_valid); end
      total++; if (occupancy !== 3'd1) begin bad++; $display("[TB] FAIL haz_occ: got %0d want 1", occupancy); end
      tick();
      wb_valid = 1'b1; wb_rd = 3'd1;
      #1;
      total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL haz_no_bypass: got %b want 0", issue_valid); end
      tick();
      wb_valid = 1'b0;
      total++; if (issue_valid !== 1'b1) begin bad++; $display("[TB] FAIL haz_after_wb_valid: got %b want 1", issue_valid); end
      total++; if (instructions !== b) begin bad++; $display("[TB] FAIL haz_after_wb_instr: got %h want %h", instructions, b); end
      tick();
      total++; if (occupancy !== 3'd0) begin bad++; $display("[TB] FAIL haz_drain_occ: got %0d want 0", occupancy); end
   endtask

   task automatic test_illegal();
      logic [31:0] st;
      do_reset();
      fpu_ready = 1'b1;
      host_valid = 1'b1; host_instr = mk(4'd7, 3'd0, 3'd0, 3'd0, 16'h0007);
      tick();
      total++; if (err_illegal !== 1'b1) begin bad++; $display("[TB] FAIL ill_op_err: got %b want 1", err_illegal); end
      total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL ill_op_valid: got %b want 0", issue_valid); end
      host_instr = mk(4'd1, 3'd6, 3'd0, 3'd0, 16'h0006);
      tick();
      host_valid = 1'b0;
      total++; if (err_illegal !== 1'b1) begin bad++; $display("[TB] FAIL ill_rd_err: got %b want 1", err_illegal); end
      total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL ill_rd_valid: got %b want 0", issue_valid); end
      tick();
      total++; if (err_illegal !== 1'b0) begin bad++; $display("[TB] FAIL ill_pulse_end: got %b want 0", err_illegal); end
      total++; if (occupancy !== 3'd0) begin bad++; $display("[TB] FAIL ill_occ: got %0d want 0", occupancy); end
      st = mk(4'd5, 3'd7, 3'd1, 3'd7, 16'h0055);
      host_valid = 1'b1; host_instr = st;
      tick();
      total++; if (instructions !== st) begin bad++; $display("[TB] FAIL ill_store_unused_fields: got %h want %h", instructions, st); end
      host_instr = mk(4'd4, 3'd5, 3'd0, 3'd0, 16'h0005);
      tick();
      host_valid = 1'b0;
      total++; if (err_illegal !== 1'b1) begin bad++; $display("[TB] FAIL ill_load_r5: got %b want 1", err_illegal); end
      tick();
      total++; if (err_illegal !== 1'b0) begin bad++; $display("[TB] FAIL ill_load_end: got %b want 0", err_illegal); end
   endtask

   task automatic test_store_order();
      logic [31:0] a, s, l;
      do_reset();
      a = mk(4'd1, 3'd2, 3'd0, 3'd0, 16'h0100);
      s = mk(4'd5, 3'd0, 3'd2, 3'd0, 16'h0200);
      l = mk(4'd4, 3'd0, 3'd0, 3'd0, 16'h0300);
      fpu_ready = 1'b1; host_valid = 1'b1; host_instr = a;
      tick();
      host_instr = s;
      tick();
      host_instr = l;
      total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL ord_store_held: got %b want 0", issue_valid); end
      tick();
      host_valid = 1'b0;
      tick();
      total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL ord_load_not_early: got %b want 0", issue_valid); end
      total++; if (occupancy !== 3'd2) begin bad++; $display("[TB] FAIL ord_occ: got %0d want 2", occupancy); end
      wb_valid = 1'b1; wb_rd = 3'd2;
      tick();
      wb_valid = 1'b0;
      total++; if (instructions !== s) begin bad++; $display("[TB] FAIL ord_first: got %h want %h", instructions, s); end
      tick();
      total++; if (instructions !== l) begin bad++; $display("[TB] FAIL ord_second: got %h want %h", instructions, l); end
      tick();
      total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL ord_drained: got %b want 0", issue_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] seq [20];
      int issued, lastCyc, maxOcc;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         seq[i] = (i % 2 == 0) ? mk(4'd0, 3'd0, 3'd0, 3'd0, 16'(i))
                               : mk(4'd5, 3'd0, 3'(i % NREG), 3'd0, 16'(16'h1000 + i));
      end
      issued = 0; lastCyc = -1; maxOcc = 0;
      fpu_ready = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (int'(occupancy) > maxOcc) maxOcc = int'(occupancy);
         if (issue_valid === 1'b1) begin
            if (issued < 20) begin
               total++; if (instructions !== seq[issued]) begin bad++; $display("[TB] FAIL b2b_instr%0d: got %h want %h", issued, instructions, seq[issued]); end
            end
            issued++;
            lastCyc = cyc;
         end
         host_valid = (cyc < 20);
         host_instr = (cyc < 20) ? seq[cyc] : '0;
         tick();
      end
      host_valid = 1'b0;
      total++; if (issued != 20) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 20", issued); end
      total++; if (lastCyc != 20) begin bad++; $display("[TB] FAIL b2b_last_cycle: got %0d want 20", lastCyc); end
      total++; if (maxOcc > 1) begin bad++; $display("[TB] FAIL b2b_max_occ: got %0d want <=1", maxOcc); end
   endtask

   initial begin
      test_reset();
      test_reset_midstream();
      test_full();
      test_hazard_wb();
      test_illegal();
      test_store_order();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpu_issue_queue.md
Name: fpu_issue_queue

Overview:
- Front end that feeds instructions to the FPU pipeline (Fetch / Decode / Execute / Writeback) and acts as the initiator of the FPU instruction interface.
- Accepts 32-bit instructions from the host, buffers them in a small FIFO, and checks register hazards against an in-flight scoreboard for the 5-entry FPU register file.
- Issues one instruction per cycle in order. Busy bits are cleared when the FPU writeback stage reports completion.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- NREG, 5, FPU architectural registers; valid indices 0..NREG-1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- host_valid  in  1  host instruction valid
- host_instr  in  32  host instruction
- host_ready  out  1  FIFO can accept; equals !full
- instructions  out  32  instruction to FPU
- issue_valid  out  1  instructions holds a valid instruction this cycle
- fpu_ready  in  1  FPU accepts instruction (stall when 0)
- wb_valid  in  1  FPU writeback of register wb_rd this cycle
- wb_rd  in  3  register written back
- err_illegal  out  1  one-cycle pulse: head instruction dropped as illegal
- occupancy  out  $clog2(DEPTH)+1  FIFO entries held

Behaviour:
- Reset: asynchronous on rst_n low.
  - FIFO empty, all busy bits 0.
  - host_ready=1, issue_valid=0, instructions=0, err_illegal=0, occupancy=0.
  - Reset mid-operation discards queued and scoreboard state. Nothing is replayed.
- Instruction fields:
  - opcode [31:28], rd [26:24], rs1 [22:20], rs2 [18:16], imm [15:0].
  - Opcodes: 0 NOP, 1 FADD, 2 FSUB, 3 FMUL (use rd, rs1, rs2); 4 LOAD (rd only); 5 STORE (rs1 only).
  - Opcodes 6..15 are illegal.
- Enqueue:
  - Occurs when host_valid && host_ready. The instruction is written at the tail.
  - Full: host_ready=0 and host_valid is ignored.
  - Enqueue and dequeue in the same cycle while full is not allowed, because host_ready is registered-derived from full.
- Head evaluation is combinational from the registered FIFO head and registered busy bits.
  - Illegal: the opcode is illegal, or a used field is >= NREG.
  - Hazard: any used source or rd has busy=1.
  - NOP counts as legal and hazard-free.
- Head actions:
  - Empty: issue_valid=0.
  - Illegal: dequeue the head, pulse err_illegal for 1 cycle, issue_valid=0. Exactly one instruction is dropped per cycle.
  - Hazard: issue_valid=0 and the head is held. There is no reordering.
  - Otherwise: issue_valid=1 and instructions=head.
- Issue handshake:
  - An instruction issues on issue_valid && fpu_ready.
  - On issue, the head is dequeued, and busy[rd] is set if the opcode writes rd (1-4).
  - NOP issues to the FPU but sets no busy bit.
  - While fpu_ready=0, issue_valid and instructions are held stable until accepted.
- Latency:
  - An instruction enqueued into an empty FIFO with no hazard is presented on issue_valid the cycle after enqueue.
  - With fpu_ready=1, throughput is 1 per cycle.
- Writeback:
  - wb_valid clears busy[wb_rd] at the clock edge.
  - wb_rd >= NREG is ignored.
  - A clear and a set of different registers in the same cycle both take effect.
  - A set and clear of the same register cannot collide, because issue requires rd not busy.
  - The hazard check does not bypass same-cycle wb_valid; the waiting instruction issues the next cycle.
- Occupancy: tail-head difference using an extra wrap bit on both pointers. The pointers wrap modulo DEPTH.
  - Full when the pointer indices are equal and the wrap bits differ.
  - Empty when the pointers are equal.
- Simultaneous enqueue and dequeue (issue or illegal drop): occupancy is unchanged and both pointers advance.

Decomposition:
- Package fpu_pkg holds:
  - opcode enum (OP_NOP..OP_STORE)
  - field bit-position constants
  - packed struct fpu_instr_t {opcode, rd, rs1, rs2, imm}
  - helper functions uses_rd/uses_rs1/uses_rs2
- One sub-module, fpu_sync_fifo (DEPTH, WIDTH=32), provides full/empty/count.
- Scoreboard and issue logic live in fpu_issue_queue.

Test Plan:
- Reset with rst_n=0 mid-stream, 3 entries queued -> occupancy=0, host_ready=1, issue_valid=0, busy all clear; the next instruction issues without a stall.
- Enqueue 4 FADD r1=r2+r3 … r4=r2+r3 with fpu_ready=0 -> occupancy=4, host_ready=0; a 5th host_valid is ignored. Raise fpu_ready -> issued in order, one per cycle.
- FADD r1=r2+r3, then FMUL r4=r1+r0 -> the second stalls with issue_valid=0. Assert wb_valid, wb_rd=1 -> FMUL issues the following cycle, not the same one.
- Opcode 7, then FADD with rd=6 -> err_illegal pulses 2 cycles consecutively, both dropped, nothing issued, busy unchanged.
- STORE rs1=2 while r2 busy -> held. LOAD r0 behind it is not issued early; ordering is preserved.
- Continuous host_valid with fpu_ready=1, no hazards, 20 instructions -> 20 issues in 21 cycles, occupancy ≤1, issued sequence identical to input.
